// File: rtl/alu_pkg.sv
// Shared opcode constants, default opcode width and result-stage state encoding.
package alu_pkg;

  localparam int OPW_DEFAULT = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative flags plus carry/overflow masking for MOV.
// Zero latency; no flow control of its own.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = OPW_DEFAULT
) (
  input  logic [WIDTH-1:0] i_result,
  input  logic [OPW-1:0]   i_op,
  input  logic             i_carry,
  input  logic             i_ovf,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_carry,
  output logic             o_ovf
);

  logic w_is_mov;

  assign w_is_mov = (i_op == OPW'(OP_MOV));
  assign o_zero   = (i_result == '0);
  assign o_neg    = i_result[WIDTH-1];
  // A MOV never goes through the adder, so its carry/ovf inputs are stale.
  assign o_carry  = i_carry & ~w_is_mov;
  assign o_ovf    = i_ovf & ~w_is_mov;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with 2-entry skid buffer; 1-cycle latency when empty.
// in_ready is a flop that drops only while both entries are occupied.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = OPW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [15:0]      result_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [OPW-1:0]   op;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
  } entry_t;

  logic        w_zero, w_neg, w_carry, w_ovf;
  logic        w_acc, w_hs;
  entry_t      w_new;
  entry_t      r_main, r_skid;
  logic [1:0]  r_state;
  logic        r_in_ready, r_out_valid;
  logic [15:0] r_count;

  alu_flag_gen #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_flag_gen (
    .i_result (in_result),
    .i_op     (in_op),
    .i_carry  (in_carry),
    .i_ovf    (in_ovf),
    .o_zero   (w_zero),
    .o_neg    (w_neg),
    .o_carry  (w_carry),
    .o_ovf    (w_ovf)
  );

  assign w_new = {in_result, in_op, w_zero, w_neg, w_carry, w_ovf};
  assign w_acc = in_valid && r_in_ready;
  assign w_hs  = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
      r_count     <= 16'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main      <= w_new;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_hs) begin
            r_main <= w_new;
          end else if (w_acc) begin
            r_skid     <= w_new;
            r_in_ready <= 1'b0;
            r_state    <= ST_TWO;
          end else if (w_hs) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_hs) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
      if (w_hs) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_result   = r_main.result;
  assign out_op       = r_main.op;
  assign out_zero     = r_main.zero;
  assign out_neg      = r_main.neg;
  assign out_carry    = r_main.carry;
  assign out_ovf      = r_main.ovf;
  assign result_count = r_count;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage that sits directly downstream of the N-bit ALU function units, including the MOV pass-through. It captures each ALU result with its opcode and carry/overflow, and computes zero/negative flags at capture. It presents results to the writeback consumer over a valid/ready handshake. A 2-entry skid buffer lets `in_ready` be a pure register output, so the ALU never sees a combinational path from the consumer's `out_ready`.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; matches the ALU units' `WIDTH`.
- `OPW`, 4, opcode width.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  the ALU result on `in_*` is valid.
- `in_ready`  out  1  the stage can accept a result; registered.
- `in_result`  in  WIDTH  ALU output, e.g. `out1` of the MOV unit.
- `in_op`  in  OPW  opcode that produced `in_result`.
- `in_carry`  in  1  carry-out from the adder/subtractor path.
- `in_ovf`  in  1  signed overflow from the adder/subtractor path.
- `out_valid`  out  1  `out_*` holds a valid entry.
- `out_ready`  in  1  the consumer takes the entry.
- `out_result`  out  WIDTH  held result.
- `out_op`  out  OPW  held opcode.
- `out_zero`  out  1  held result == 0.
- `out_neg`  out  1  held result[WIDTH-1].
- `out_carry`  out  1  held carry; forced 0 for OP_MOV.
- `out_ovf`  out  1  held overflow; forced 0 for OP_MOV.
- `result_count`  out  16  number of completed output handshakes.

## Operation
- Input accept: `in_valid && in_ready`.
- Output handshake: `out_valid && out_ready`.
- Entry contents: {result, op, zero, neg, carry, ovf}. `zero`, `neg` and the MOV masking are computed from `in_*` at capture, not at output.
- Storage: main register (drives `out_*`) plus skid register.
- States:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: `out_valid`=1, `in_ready`=1.
  - TWO: `out_valid`=1, `in_ready`=0.
- EMPTY:
  - accept → load main, go to ONE.
  - otherwise stay.
- ONE:
  - accept only → load skid, go to TWO.
  - output handshake only → go to EMPTY.
  - accept and output handshake in the same cycle → load main with the new entry, stay ONE.
  - neither → hold.
- TWO:
  - output handshake → move skid to main, go to ONE.
  - otherwise hold.
  - No accept is possible because `in_ready`=0.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- `result_count`: +1 on every output handshake; wraps from 16'hFFFF to 16'h0000.
- Data hold: `out_*` is stable while `out_valid && !out_ready`.
- Input hold: `in_*` are ignored when `in_ready`=0, even if `in_valid`=1.

## Timing
- Latency: an entry accepted at edge N appears on `out_*` after edge N when the stage was EMPTY. It appears later if older entries are still queued.
- Throughput: 1 entry/cycle while `out_ready` is held high.
- `in_ready`: a flop. It falls on the edge that enters TWO and rises on the edge that leaves TWO.
- No combinational path from `out_ready` to `in_ready`. No combinational path from `in_*` to `out_*`.
- Reset, effective immediately on `rst_n`=0 without waiting for `clk`:
  - state=EMPTY, `in_ready`=1, `out_valid`=0.
  - `out_result`, `out_op`, `out_zero`, `out_neg`, `out_carry`, `out_ovf` all 0.
  - `result_count`=0.
- Reset mid-operation: all held entries are discarded; the consumer sees `out_valid` drop asynchronously.
- Reset release: the first accept can occur on the first rising edge after `rst_n` goes high.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants, including `OP_MOV`;
  - the `OPW` default;
  - the entry-state encoding (EMPTY/ONE/TWO) as a 2-bit localparam set.
- One sub-module: `alu_flag_gen` (combinational). Inputs: result, op, carry, ovf. Outputs: zero, neg, masked carry, masked ovf. It is instantiated once, on the input side.
- Everything else lives in `alu_result_stage`.

## Test plan
- Reset and single pass:
  - Stimulus: assert `rst_n`=0 mid-clock, release; then `in_valid`=1, `in_result`=32'h0000_0000, `in_op`=OP_ADD, `in_carry`=1, `out_ready`=1.
  - Response: all outputs 0 during reset. One cycle after the accept: `out_valid`=1, `out_zero`=1, `out_neg`=0, `out_carry`=1. `result_count` becomes 1 at the next edge.
- MOV masking:
  - Stimulus: `in_result`=32'h8000_0001, `in_op`=OP_MOV, `in_carry`=1, `in_ovf`=1.
  - Response: `out_result`=32'h8000_0001, `out_neg`=1, `out_zero`=0, `out_carry`=0, `out_ovf`=0.
- Backpressure fill:
  - Stimulus: `out_ready`=0; push 32'hA, 32'hB, then hold 32'hC with `in_valid`=1.
  - Response: `in_ready`=0 after the second accept. `out_result` stays 32'hA. 32'hC is not accepted.
  - Then raise `out_ready`=1 for 3 cycles.
  - Response: outputs A, B, C in order; `result_count`=3.
- Simultaneous accept and handshake in ONE:
  - Stimulus: stream 8 values 1..8 back-to-back with `out_ready`=1 throughout.
  - Response: `in_ready` never drops; outputs 1..8 on consecutive cycles.
- Reset while TWO:
  - Stimulus: fill with 32'h11 and 32'h22, pulse `rst_n` low.
  - Response: `out_valid`=0 immediately; after release, the next accepted 32'h33 is the first output.
- Counter wrap:
  - Stimulus: force 65536 handshakes.
  - Response: `result_count` goes 16'hFFFF → 16'h0000.
